// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB pipeline has fixed priority, while
// load-return (ld) and mul/div (md) share leftover slots round-robin.
// A starvation counter stalls the pipe for one cycle so a waiting ld/md
// request is always serviced.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pipe_valid/rd/data         WB-stage write request
//   pipe_stall                 comb: WB stage must hold its request this cycle
//   ld_valid/rd/data, ld_ready load-return request / accept (comb)
//   md_valid/rd/data, md_ready mul/div request / accept (comb)
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   starve_cnt                 debug view of the starvation counter
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [3:0]      starve_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic            rr_ptr;
    logic [3:0]      cnt;

    logic            sec_req;
    logic            force_sec;
    logic            pick_md;
    logic            grant_pipe;
    logic            grant_ld;
    logic            grant_md;
    logic            sec_grant;
    logic            any_grant;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_data;

    always_comb begin
        sec_req    = ld_valid | md_valid;
        force_sec  = (cnt == CNT_MAX) && sec_req;
        // md wins when it is the only requester, or when both request and
        // the round-robin pointer favours md.
        pick_md    = md_valid && (!ld_valid || rr_ptr);
        pipe_stall = 1'b0;
        grant_pipe = 1'b0;
        grant_ld   = 1'b0;
        grant_md   = 1'b0;
        if (!rst) begin
            if (force_sec) begin
                pipe_stall = 1'b1;
                grant_ld   = !pick_md;
                grant_md   = pick_md;
            end else if (pipe_valid) begin
                grant_pipe = 1'b1;
            end else if (sec_req) begin
                grant_ld   = !pick_md;
                grant_md   = pick_md;
            end
        end
        sec_grant = grant_ld | grant_md;
        any_grant = grant_pipe | sec_grant;
        g_rd      = '0;
        g_data    = '0;
        unique case (1'b1)
            grant_pipe: begin
                g_rd   = pipe_rd;
                g_data = pipe_data;
            end
            grant_ld: begin
                g_rd   = ld_rd;
                g_data = ld_data;
            end
            grant_md: begin
                g_rd   = md_rd;
                g_data = md_data;
            end
            default: begin
                g_rd   = '0;
                g_data = '0;
            end
        endcase
    end

    assign ld_ready   = grant_ld;
    assign md_ready   = grant_md;
    assign starve_cnt = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            cnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (grant_ld) begin
                rr_ptr <= 1'b1;
            end else if (grant_md) begin
                rr_ptr <= 1'b0;
            end

            if (sec_grant || !sec_req) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end

            // x0 requests are accepted but never produce a write.
            rf_we <= any_grant && (g_rd != 5'd0);
            if (any_grant) begin
                rf_waddr <= g_rd;
                rf_wdata <= g_data;
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three writeback sources:
  - the in-order pipeline WB stage (pipe);
  - the load-return unit (ld);
  - the multi-cycle mul/div unit (md).
- Sits between the WB-stage mux (driven by the writeback select) and the register file.
- The pipeline has fixed priority. ld and md share the leftover slots round-robin.
- A starvation counter forces a one-cycle pipeline stall so a waiting secondary source is always serviced.

Parameters:
- STARVE_MAX, default 4: cycles a secondary request may wait before the pipeline is stalled for it (legal range 1..15).
- XLEN, default 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  WB stage has a result to write
- pipe_rd  in  5  destination register of the pipe result
- pipe_data  in  XLEN  pipe result data
- pipe_stall  out  1  combinational; stalls WB stage this cycle, so pipe must hold its valid/rd/data
- ld_valid  in  1  load return request
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- ld_ready  out  1  combinational; load request accepted this cycle
- md_valid  in  1  mul/div result request
- md_rd  in  5  mul/div destination register
- md_data  in  XLEN  mul/div result data
- md_ready  out  1  combinational; mul/div request accepted this cycle
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  5  registered register-file write address
- rf_wdata  out  XLEN  registered register-file write data
- starve_cnt  out  4  debug view of the starvation counter

Behaviour:
- State:
  - rr_ptr (1 bit): 0 means ld is preferred next, 1 means md is preferred next.
  - cnt (4 bits).
  - output registers rf_we, rf_waddr, rf_wdata.
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, cnt=0, rr_ptr=0. pipe_stall, ld_ready and md_ready are forced 0 while rst is high.
- Definitions:
  - sec_req = ld_valid | md_valid.
  - force = (cnt == STARVE_MAX) & sec_req.
- Grant, evaluated each cycle:
  - If force: pipe is not granted and pipe_stall=1. The secondary chosen by rr_ptr is granted (or the only valid one).
  - Else if pipe_valid: pipe is granted, pipe_stall=0, ld_ready=md_ready=0.
  - Else if sec_req: one secondary is granted. If both are valid, the one selected by rr_ptr wins; otherwise the valid one wins.
  - Else: no grant.
- At most one of the grants (pipe, ld_ready, md_ready) is high in any cycle.
- rr_ptr update: on an ld grant rr_ptr<=1; on an md grant rr_ptr<=0. Pipe grants and idle cycles leave rr_ptr unchanged.
- Write path, one-cycle latency (grant in cycle N, write visible in cycle N+1):
  - rf_we <= granted & (granted_rd != 0).
  - rf_waddr and rf_wdata are loaded from the granted source.
  - With no grant, rf_we <= 0 and rf_waddr/rf_wdata hold their previous values.
  - A request to x0 is still accepted (ready=1, counter rules apply) but never writes.
- Counter:
  - Secondary granted: cnt <= 0.
  - sec_req and no secondary granted: cnt <= cnt + 1, saturating at STARVE_MAX.
  - No sec_req: cnt <= 0.
- Handshake: each secondary source holds valid/rd/data stable until it sees ready=1 in a cycle. Transfer occurs on the clock edge where valid & ready.
- Simultaneous events:
  - pipe, ld and md all valid with cnt < STARVE_MAX: pipe wins.
  - pipe, ld and md all valid with cnt == STARVE_MAX: rr_ptr decides between ld and md, pipe stalls one cycle, cnt returns to 0.
- Reset mid-operation: a request accepted in the cycle rst rises is dropped (no write). Sources must re-present after reset.
- No same-register ordering checks are made; hazard control upstream guarantees that pipe and secondaries never target the same rd out of order.

Test Plan:
- Reset mid-run: assert rst while ld_valid=1, ld_rd=5 -> rf_we=0, starve_cnt=0, ld_ready=0 immediately; after release, the first grant goes to ld (rr_ptr=0).
- Only ld_valid=1, ld_rd=7, ld_data=0xDEADBEEF at cycle N -> ld_ready=1 at N; rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF at N+1; rf_we=0 at N+2 when ld_valid has dropped.
- pipe_valid held 1 (rd=3) with md_valid=1 (rd=9), STARVE_MAX=4 -> pipe written for 4 cycles while starve_cnt goes 1,2,3,4. On the 5th cycle pipe_stall=1 and md_ready=1; the next cycle writes x9; starve_cnt returns to 0.
- ld and md both valid continuously, pipe idle -> grants alternate ld, md, ld, md starting with ld; never two grants in one cycle.
- pipe_valid=1 with pipe_rd=0, data=0x1234 -> pipe_stall=0 and rf_we stays 0 the next cycle. Then md_rd=0 with md_valid=1 and pipe idle -> md_ready=1, rf_we=0, starve_cnt=0.
- All three valid with starve_cnt=STARVE_MAX and rr_ptr=1 -> md granted, pipe_stall=1, ld_ready=0; the following cycle ld waits and pipe wins again.
